// File: rtl/pvmac_engine_if.sv
// Request/response bundle for pvmac_engine: request handshake with operands in,
// result handshake with result and illegal flag out.
interface pvmac_engine_if #(
   parameter int XLEN = 32
);
   logic            valid_in;
   logic            ready_in;
   logic [2:0]      ctrl;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            valid_out;
   logic            ready_out;
   logic [XLEN-1:0] result;
   logic            illegal;

   modport master (
      output valid_in, ctrl, a, b, ready_out,
      input  ready_in, valid_out, result, illegal
   );

   modport slave (
      input  valid_in, ctrl, a, b, ready_out,
      output ready_in, valid_out, result, illegal
   );
endinterface

// File: rtl/pvmac_engine.sv
// Packed-SIMD add / multiply / dot-product / multiply-accumulate engine with a
// one-product-per-cycle multiplier and an internal accumulator.
module pvmac_engine #(
   parameter int XLEN = 32,
   parameter int ELEN = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   pvmac_engine_if.slave bus
);
   localparam int NLANES = XLEN / ELEN;
   localparam int NHALF  = NLANES / 2;
   localparam int IDXW   = $clog2(NLANES) + 1;

   localparam logic [2:0] OP_PVADD  = 3'b000;
   localparam logic [2:0] OP_PVADDS = 3'b001;
   localparam logic [2:0] OP_PVMULU = 3'b011;
   localparam logic [2:0] OP_PVMAC  = 3'b101;
   localparam logic [2:0] OP_PVCLR  = 3'b110;
   localparam logic [2:0] OP_ILL    = 3'b111;

   typedef enum logic [2:0] {S_IDLE, S_ADD, S_MUL, S_RED, S_DONE} state_t;

   state_t                   r_state;
   state_t                   w_state_next;
   logic                     w_ready_in;
   logic                     w_valid_out;
   logic [2:0]               r_ctrl;
   logic [XLEN-1:0]          r_a;
   logic [XLEN-1:0]          r_b;
   logic [XLEN-1:0]          r_result;
   logic                     r_illegal;
   logic [XLEN-1:0]          r_acc;
   logic [XLEN-1:0]          r_sum;
   logic signed [2*ELEN-1:0] r_prod;
   logic [IDXW-1:0]          r_idx;

   logic [XLEN-1:0]          w_add;
   logic [XLEN-1:0]          w_adds;
   logic [XLEN-1:0]          w_pack;
   logic [XLEN-1:0]          w_dot_sum;
   logic [XLEN-1:0]          w_mac_res;
   logic [IDXW-1:0]          w_lane;
   logic signed [ELEN-1:0]   w_a_op;
   logic signed [ELEN-1:0]   w_b_op;
   logic signed [2*ELEN-1:0] w_prod;
   logic                     w_is_mul;
   logic                     w_dot;
   logic                     w_last_dot;
   logic                     w_last_mul;

   // Opcodes 010..101 are exactly those whose top two bits differ.
   assign w_is_mul   = bus.ctrl[2] ^ bus.ctrl[1];
   assign w_dot      = r_ctrl[2];
   assign w_last_dot = (r_idx == IDXW'(NLANES - 1));
   assign w_last_mul = (r_idx == IDXW'(NHALF));

   for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
      logic signed [ELEN:0] w_sum;
      assign w_sum = {r_a[gi*ELEN+ELEN-1], r_a[gi*ELEN +: ELEN]}
                   + {r_b[gi*ELEN+ELEN-1], r_b[gi*ELEN +: ELEN]};
      assign w_add[gi*ELEN +: ELEN]  = w_sum[ELEN-1:0];
      assign w_adds[gi*ELEN +: ELEN] = (w_sum[ELEN] == w_sum[ELEN-1]) ? w_sum[ELEN-1:0]
                                     : {w_sum[ELEN], {(ELEN-1){~w_sum[ELEN]}}};
   end

   // Lane index past the last product selects nothing, so the operand mux yields zero.
   always_comb begin
      w_lane = (r_ctrl == OP_PVMULU) ? IDXW'(NHALF) + r_idx : r_idx;
      w_a_op = '0;
      w_b_op = '0;
      for (int i = 0; i < NLANES; i++) begin
         if (int'(w_lane) == i) begin
            w_a_op = r_a[i*ELEN +: ELEN];
            w_b_op = r_b[i*ELEN +: ELEN];
         end
      end
      w_prod = w_a_op * w_b_op;
   end

   // r_prod holds the product from the previous MUL cycle; it is folded one cycle late.
   always_comb begin
      w_pack = r_sum;
      for (int j = 0; j < NHALF; j++) begin
         if (int'(r_idx) == j + 1) w_pack[j*2*ELEN +: 2*ELEN] = r_prod;
      end
      w_dot_sum = r_sum + XLEN'(r_prod);
      w_mac_res = w_dot_sum + (r_ctrl == OP_PVMAC ? r_acc : '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_ready_in   = 1'b0;
      w_valid_out  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready_in = 1'b1;
            if (bus.valid_in) w_state_next = w_is_mul ? S_MUL : S_ADD;
         end
         S_ADD: w_state_next = S_DONE;
         S_MUL: begin
            if (w_dot) begin
               if (w_last_dot) w_state_next = S_RED;
            end else if (w_last_mul) begin
               w_state_next = S_DONE;
            end
         end
         S_RED: w_state_next = S_DONE;
         S_DONE: begin
            w_valid_out = 1'b1;
            if (bus.ready_out) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ctrl    <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_result  <= '0;
         r_illegal <= 1'b0;
         r_acc     <= '0;
         r_sum     <= '0;
         r_prod    <= '0;
         r_idx     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.valid_in) begin
                  r_a    <= bus.a;
                  r_b    <= bus.b;
                  r_ctrl <= bus.ctrl;
                  r_idx  <= '0;
                  r_sum  <= '0;
               end
            end
            S_ADD: begin
               r_illegal <= (r_ctrl == OP_ILL);
               case (r_ctrl)
                  OP_PVADD:  r_result <= w_add;
                  OP_PVADDS: r_result <= w_adds;
                  OP_PVCLR: begin
                     r_result <= r_acc;
                     r_acc    <= '0;
                  end
                  default:   r_result <= '0;
               endcase
            end
            S_MUL: begin
               r_idx  <= r_idx + IDXW'(1);
               r_prod <= w_prod;
               if (r_idx != '0) r_sum <= w_dot ? w_dot_sum : w_pack;
               if (!w_dot && w_last_mul) begin
                  r_result  <= w_pack;
                  r_illegal <= 1'b0;
               end
            end
            S_RED: begin
               r_result  <= w_mac_res;
               r_illegal <= 1'b0;
               if (r_ctrl == OP_PVMAC) r_acc <= w_mac_res;
            end
            default: ;
         endcase
      end
   end

   assign bus.ready_in  = w_ready_in;
   assign bus.valid_out = w_valid_out;
   assign bus.result    = r_result;
   assign bus.illegal   = r_illegal;
endmodule
